// File: rtl/sha256_hash_ctrl.sv
// rtl/sha256_hash_ctrl.sv - sequencer between message packer, SHA-256 core and UART TX
module sha256_hash_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_BLOCKS_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BLOCKS_W-1:0] cfg_num_blocks_in,
    input  logic [DATA_WIDTH-1:0]   mp_data_in,
    input  logic                    mp_dv_in,
    output logic [DATA_WIDTH-1:0]   core_word_out,
    output logic                    core_word_valid_out,
    output logic                    core_start_out,
    output logic                    core_init_out,
    input  logic                    core_done_in,
    input  logic [255:0]            core_digest_in,
    output logic [7:0]              tx_byte_out,
    output logic                    tx_dv_out,
    input  logic                    tx_active_in,
    input  logic                    tx_done_in,
    output logic                    busy_out,
    output logic                    err_overrun_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_START,
        S_WAIT_CORE,
        S_TX_BYTE,
        S_TX_WAIT
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [DATA_WIDTH-1:0]   msg_buf [16];
    logic [3:0]              word_cnt;
    logic [NUM_BLOCKS_W-1:0] blocks_left;
    logic                    first_r;
    logic [255:0]            dig_r;
    logic [4:0]              byte_cnt;
    logic                    err_r;
    logic                    tx_dv_r;
    logic [7:0]              tx_byte_r;
    logic                    accepting;

    // Words are only taken while collecting a block; anything else is an overrun.
    assign accepting = (state == S_IDLE) || (state == S_LOAD);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (mp_dv_in) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mp_dv_in && (word_cnt == 4'd15)) begin
                    next_state = S_FEED;
                end
            end
            S_FEED: begin
                if (word_cnt == 4'd15) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                next_state = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done_in) begin
                    next_state = (blocks_left > NUM_BLOCKS_W'(1)) ? S_LOAD : S_TX_BYTE;
                end
            end
            S_TX_BYTE: begin
                if (!tx_active_in) begin
                    next_state = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (tx_done_in) begin
                    next_state = (byte_cnt == 5'd31) ? S_IDLE : S_TX_BYTE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode; the TX byte strobe is registered so it lands one cycle after TX_BYTE is entered
    always_comb begin
        core_word_valid_out = (state == S_FEED);
        core_word_out       = (state == S_FEED) ? msg_buf[word_cnt] : '0;
        core_start_out      = (state == S_START);
        core_init_out       = (state == S_START) && first_r;
        busy_out            = (state != S_IDLE);
        tx_dv_out           = tx_dv_r;
        tx_byte_out         = tx_byte_r;
        err_overrun_out     = err_r;
    end

    // Block buffer: holds no reset since its contents are only read after a full block is written
    always_ff @(posedge clk) begin
        if (accepting && mp_dv_in) begin
            msg_buf[(state == S_IDLE) ? 4'd0 : word_cnt] <= mp_data_in;
        end
    end

    // Counters, chaining flags, digest capture and TX byte strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt    <= '0;
            blocks_left <= '0;
            first_r     <= 1'b0;
            dig_r       <= '0;
            byte_cnt    <= '0;
            err_r       <= 1'b0;
            tx_dv_r     <= 1'b0;
            tx_byte_r   <= '0;
        end else begin
            tx_dv_r   <= 1'b0;
            tx_byte_r <= '0;
            if (mp_dv_in && !accepting) begin
                err_r <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (mp_dv_in) begin
                        blocks_left <= (cfg_num_blocks_in == '0) ? NUM_BLOCKS_W'(1) : cfg_num_blocks_in;
                        first_r     <= 1'b1;
                        word_cnt    <= 4'd1;
                    end
                end
                S_LOAD: begin
                    if (mp_dv_in) begin
                        word_cnt <= word_cnt + 4'd1;
                    end
                end
                S_FEED: begin
                    word_cnt <= word_cnt + 4'd1;
                end
                S_START: begin
                    first_r <= 1'b0;
                end
                S_WAIT_CORE: begin
                    if (core_done_in) begin
                        if (blocks_left > NUM_BLOCKS_W'(1)) begin
                            blocks_left <= blocks_left - NUM_BLOCKS_W'(1);
                        end else begin
                            dig_r    <= core_digest_in;
                            byte_cnt <= '0;
                        end
                    end
                end
                S_TX_BYTE: begin
                    if (!tx_active_in) begin
                        tx_dv_r   <= 1'b1;
                        tx_byte_r <= dig_r[8'd255 - {byte_cnt, 3'b000} -: 8];
                    end
                end
                S_TX_WAIT: begin
                    if (tx_done_in && (byte_cnt != 5'd31)) begin
                        byte_cnt <= byte_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_hash_ctrl.sv
// tb/tb_sha256_hash_ctrl.sv - scoreboard bench for sha256_hash_ctrl
module tb_sha256_hash_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   cfg_num_blocks;
    logic [31:0]  mp_data;
    logic         mp_dv;
    logic [31:0]  core_word;
    logic         core_word_valid;
    logic         core_start;
    logic         core_init;
    logic         core_done;
    logic [255:0] core_digest;
    logic [7:0]   tx_byte;
    logic         tx_dv;
    logic         tx_active;
    logic         tx_done;
    logic         busy;
    logic         err_overrun;
    logic         tx_busy;
    logic         tx_hold;

    assign tx_active = tx_busy | tx_hold;

    sha256_hash_ctrl #(.DATA_WIDTH(32), .NUM_BLOCKS_W(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_num_blocks_in   (cfg_num_blocks),
        .mp_data_in          (mp_data),
        .mp_dv_in            (mp_dv),
        .core_word_out       (core_word),
        .core_word_valid_out (core_word_valid),
        .core_start_out      (core_start),
        .core_init_out       (core_init),
        .core_done_in        (core_done),
        .core_digest_in      (core_digest),
        .tx_byte_out         (tx_byte),
        .tx_dv_out           (tx_dv),
        .tx_active_in        (tx_active),
        .tx_done_in          (tx_done),
        .busy_out            (busy),
        .err_overrun_out     (err_overrun)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    logic [31:0]  exp_word_q [$];
    bit           exp_init_q [$];
    logic [255:0] digest_q   [$];
    logic [7:0]   exp_byte_q [$];

    int checks = 0;
    int fails  = 0;
    int cyc = 0;
    int last16_cyc = 0;
    int last_done_cyc = 0;
    int done_count = 0;
    int tx_total = 0;
    int msg_tx_base = 0;
    int min_core_delay = 0;
    bit chk_tx_lat = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops expectations whenever the DUT presents something
    initial begin
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (core_word_valid) begin
                if (exp_word_q.size() == 0) check("core_word_unexpected", 1, 0);
                else check("core_word", core_word, exp_word_q.pop_front());
                if (!prev_valid) check("feed_latency", cyc - last16_cyc, 1);
            end
            prev_valid = core_word_valid;
            if (core_start) begin
                if (exp_init_q.size() == 0) check("core_start_unexpected", 1, 0);
                else check("core_init", core_init, exp_init_q.pop_front());
                check("start_latency", cyc - last16_cyc, 17);
            end
            if (tx_dv) begin
                if (exp_byte_q.size() == 0) check("tx_byte_unexpected", 1, 0);
                else check("tx_byte", tx_byte, exp_byte_q.pop_front());
                if (tx_total == msg_tx_base && chk_tx_lat) check("tx_latency", cyc - last_done_cyc, 2);
                tx_total++;
            end
        end
    end

    // Core model: answers each start with a done pulse after a random delay
    initial begin
        int d;
        core_done = 1'b0;
        core_digest = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                d = $urandom_range(3, 12);
                if (d < min_core_delay) d = min_core_delay;
                repeat (d) @(posedge clk);
                #1;
                core_done = 1'b1;
                core_digest = (digest_q.size() != 0) ? digest_q.pop_front()
                                                     : {8{$urandom()}};
                last_done_cyc = cyc;
                done_count++;
                @(posedge clk);
                #1;
                core_done = 1'b0;
                core_digest = {8{$urandom()}};
            end
        end
    end

    // UART TX model: busy for a few cycles after each byte, then a done pulse
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                @(posedge clk);
                #1;
                tx_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                tx_busy = 1'b0;
                tx_done = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_block(input logic [31:0] w [16]);
        for (int i = 0; i < 16; i++) begin
            mp_data = w[i];
            mp_dv = 1'b1;
            if (i == 15) last16_cyc = cyc;
            step(1);
            mp_dv = 1'b0;
            if (i < 15) step($urandom_range(0, 2));
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int k;
        k = 0;
        while (done_count < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (done_count < target) check(name, 0, 1);
    endtask

    task automatic run_msg(input int cfg_v, input bit abc, input bit overrun, input bit hold);
        int n;
        int base_done;
        int k;
        logic [31:0]  blk [16];
        logic [255:0] dg;
        n = (cfg_v == 0) ? 1 : cfg_v;
        cfg_num_blocks = 8'(cfg_v);
        msg_tx_base = tx_total;
        chk_tx_lat = !hold;
        min_core_delay = overrun ? 10 : 0;
        base_done = done_count;
        tx_hold = hold;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 16; i++) begin
                blk[i] = abc ? ((i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0)
                             : $urandom();
                exp_word_q.push_back(blk[i]);
            end
            exp_init_q.push_back(b == 0);
            dg = abc ? ABC_DIGEST : {$urandom(), $urandom(), $urandom(), $urandom(),
                                     $urandom(), $urandom(), $urandom(), $urandom()};
            digest_q.push_back(dg);
            if (b == n - 1) begin
                for (int j = 0; j < 32; j++) exp_byte_q.push_back(8'(dg >> (248 - 8 * j)));
            end
            send_block(blk);
            if (b < n - 1) begin
                wait_done(base_done + b + 1, "timeout_block_done");
                step(1);
            end
        end
        if (overrun) begin
            k = 0;
            while (!core_start && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (!core_start) check("timeout_start", 0, 1);
            step(3);
            mp_data = $urandom();
            mp_dv = 1'b1;
            step(1);
            mp_dv = 1'b0;
            @(negedge clk);
            check("err_after_overrun", err_overrun, 1);
        end
        if (hold) begin
            int dv_seen;
            dv_seen = 0;
            wait_done(base_done + n, "timeout_hold_done");
            repeat (100) begin
                @(negedge clk);
                if (tx_dv) dv_seen++;
            end
            check("no_tx_while_active", dv_seen, 0);
            step(1);
            tx_hold = 1'b0;
        end
        k = 0;
        @(negedge clk);
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("busy_clear", busy, 0);
        check("tx_pulse_count", tx_total - msg_tx_base, 32);
        check("words_left", exp_word_q.size(), 0);
        check("starts_left", exp_init_q.size(), 0);
        check("bytes_left", exp_byte_q.size(), 0);
        check("digests_left", digest_q.size(), 0);
        step(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] blk [16];
        rst = 1'b1;
        cfg_num_blocks = 8'd1;
        mp_data = '0;
        mp_dv = 1'b0;
        tx_hold = 1'b0;
        step(3);
        check("reset_outputs",
              {core_word, core_word_valid, core_start, core_init, tx_byte, tx_dv, busy, err_overrun}, 0);
        rst = 1'b0;
        step(2);

        run_msg(1, 1'b1, 1'b0, 1'b0);
        check("err_clear_after_abc", err_overrun, 0);
        run_msg(2, 1'b0, 1'b0, 1'b0);
        run_msg(0, 1'b0, 1'b0, 1'b0);
        run_msg(1, 1'b0, 1'b0, 1'b1);
        check("err_clear_before_overrun", err_overrun, 0);
        run_msg(2, 1'b0, 1'b1, 1'b0);
        check("err_sticky", err_overrun, 1);
        run_msg(1, 1'b0, 1'b0, 1'b0);
        check("err_still_sticky", err_overrun, 1);

        cfg_num_blocks = 8'd1;
        for (int i = 0; i < 16; i++) begin
            blk[i] = $urandom();
            exp_word_q.push_back(blk[i]);
        end
        send_block(blk);
        step(7);
        rst = 1'b1;
        step(1);
        check("reset_mid_feed",
              {core_word, core_word_valid, core_start, core_init, tx_byte, tx_dv, busy, err_overrun}, 0);
        rst = 1'b0;
        exp_word_q.delete();
        exp_init_q.delete();
        digest_q.delete();
        exp_byte_q.delete();
        step(2);
        run_msg(1, 1'b0, 1'b0, 1'b0);

        for (int m = 0; m < 4; m++) run_msg($urandom_range(0, 3), 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
